// File: rtl/alu_32bit_driver.sv
// Request FIFO and sequencer feeding an external combinational alu_32bit.
// Requests are popped one at a time, the ALU settles for a cycle, and the tagged result is returned.
module alu_32bit_driver #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_first,
  input  logic [31:0]      req_second,
  output logic [2:0]       alu_op,
  output logic [31:0]      alu_first,
  output logic [31:0]      alu_second,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_illegal,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  state_t state_next;

  logic [2:0]       fifo_op     [DEPTH];
  logic [31:0]      fifo_first  [DEPTH];
  logic [31:0]      fifo_second [DEPTH];
  logic [TAG_W-1:0] fifo_tag    [DEPTH];

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [TAG_W-1:0] tag_cnt;
  logic [TAG_W-1:0] cur_tag;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             op_illegal;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign req_ready  = !full;
  assign push       = req_valid && !full;
  assign busy       = (state != IDLE) || !empty;
  assign op_illegal = (alu_op == 3'b011) || (alu_op == 3'b100) || (alu_op == 3'b101);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // the sender holds its payload stable while valid is high and ready is low.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = EXEC;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr[AW-1:0]]     <= req_op;
      fifo_first[wr_ptr[AW-1:0]]  <= req_first;
      fifo_second[wr_ptr[AW-1:0]] <= req_second;
      fifo_tag[wr_ptr[AW-1:0]]    <= tag_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tag_cnt     <= '0;
      cur_tag     <= '0;
      alu_op      <= '0;
      alu_first   <= '0;
      alu_second  <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_tag     <= '0;
      rsp_illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (push) begin
        wr_ptr  <= wr_ptr + {{AW{1'b0}}, 1'b1};
        tag_cnt <= tag_cnt + {{(TAG_W-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + {{AW{1'b0}}, 1'b1};
        alu_op     <= fifo_op[rd_ptr[AW-1:0]];
        alu_first  <= fifo_first[rd_ptr[AW-1:0]];
        alu_second <= fifo_second[rd_ptr[AW-1:0]];
        cur_tag    <= fifo_tag[rd_ptr[AW-1:0]];
      end
      if (state == EXEC) begin
        rsp_result  <= alu_result;
        rsp_zero    <= alu_zero;
        rsp_tag     <= cur_tag;
        rsp_illegal <= op_illegal;
        rsp_valid   <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_32bit_driver.sv
// Directed bench for alu_32bit_driver with a behavioural alu_32bit attached to the alu_* ports.
module tb_alu_32bit_driver;

  localparam int W = 38;  // {tag[3:0], illegal, zero, result[31:0]}

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_first;
  logic [31:0] req_second;
  logic [2:0]  alu_op;
  logic [31:0] alu_first;
  logic [31:0] alu_second;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic [3:0]  rsp_tag;
  logic        rsp_illegal;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          hs_cyc = 0;
  logic [3:0]  exp_tag = 4'd0;
  logic [W-1:0] exp_q[$];

  alu_32bit_driver #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_first(req_first), .req_second(req_second),
    .alu_op(alu_op), .alu_first(alu_first), .alu_second(alu_second),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
    .rsp_illegal(rsp_illegal), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // external alu_32bit stand-in
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_first & alu_second;
      3'b001:  alu_result = alu_first | alu_second;
      3'b010:  alu_result = alu_first + alu_second;
      3'b110:  alu_result = alu_first - alu_second;
      3'b111:  alu_result = ($signed(alu_first) < $signed(alu_second)) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    exp_tag = 4'd0;
  endtask

  // driver: present a request and hold it until accepted
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic ill);
    int n;
    exp_q.push_back({exp_tag, ill, (res == 32'd0), res});
    exp_tag    = exp_tag + 4'd1;
    req_valid  = 1'b1;
    req_op     = op;
    req_first  = a;
    req_second = b;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("req_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // scoreboard side: wait for a response and compare against the queue head
  task automatic recv();
    int n;
    logic [W-1:0] e;
    rsp_ready = 1'b1;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rsp_wait", {31'd0, rsp_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("rsp_result", rsp_result, e[31:0]);
      check("rsp_zero", {31'd0, rsp_zero}, {31'd0, e[32]});
      check("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, e[33]});
      check("rsp_tag", {28'd0, rsp_tag}, {28'd0, e[37:34]});
    end
    @(posedge clk);
    @(negedge clk);
    hs_cyc = cyc;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prev;
    req_valid = 1'b0; req_op = 3'd0; req_first = 32'd0; req_second = 32'd0;
    rsp_ready = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    do_reset();

    // reset state
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_alu_first", alu_first, 32'd0);
    check("rst_alu_op", {29'd0, alu_op}, 32'd0);
    check("rst_rsp_tag", {28'd0, rsp_tag}, 32'd0);

    // 1: single SUB with latency check
    rsp_ready = 1'b0;
    send(3'b110, 32'd2, 32'd1, 32'd1, 1'b0);
    check("lat_n_valid", {31'd0, rsp_valid}, 32'd0);
    check("lat_n_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("lat_n1_valid", {31'd0, rsp_valid}, 32'd0);
    check("lat_n1_alu_op", {29'd0, alu_op}, 32'd6);
    check("lat_n1_alu_first", alu_first, 32'd2);
    @(negedge clk);
    check("lat_n2_valid", {31'd0, rsp_valid}, 32'd1);
    recv();
    check("alu_hold_idle", alu_first, 32'd2);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // 2: AND all-ones, SUB to zero, OR, SLT
    send(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    recv();
    send(3'b110, 32'd5, 32'd5, 32'd0, 1'b0);
    recv();
    send(3'b001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0);
    recv();
    send(3'b111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    recv();

    // 3: backpressure, capacity DEPTH+1, stable hold, 1 per 2 cycles drain
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(3'b010, i, 32'd10, i + 10, 1'b0);
      if (i == 3) check("bp_ready_after4", {31'd0, req_ready}, 32'd1);
    end
    check("bp_ready_after5", {31'd0, req_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_hold_tag", {28'd0, rsp_tag}, 32'd5);
      check("bp_hold_result", rsp_result, 32'd10);
    end
    rsp_ready = 1'b1;
    fork
      send(3'b010, 32'd5, 32'd10, 32'd15, 1'b0);
      begin
        prev = 0;
        for (int k = 0; k < 6; k++) begin
          recv();
          if (k > 0) check("bp_gap", hs_cyc - prev, 32'd2);
          prev = hs_cyc;
        end
      end
    join

    // 4: illegal op still returns a response
    send(3'b011, 32'd7, 32'd3, 32'd0, 1'b1);
    recv();
    check("ill_busy_after", {31'd0, busy}, 32'd0);

    // 5: tag wrap from a fresh reset
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send(3'b010, i, 32'd1, i + 1, 1'b0);
      recv();
    end

    // 6: reset mid-operation
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(3'b001, i, 32'd0, i, 1'b0);
    check("mid_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    do_reset();
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    send(3'b110, 32'd9, 32'd4, 32'd5, 1'b0);
    recv();
    repeat (3) @(negedge clk);
    check("mid_end_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_end_busy", {31'd0, busy}, 32'd0);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_32bit_driver.md
Name: alu_32bit_driver

Overview:
Initiator-side front end for the combinational alu_32bit.
- Accepts ALU operation requests (op, first, second) over a valid/ready handshake and buffers them in a small FIFO.
- Drives the operands and op into an external alu_32bit instance from registers.
- One cycle later, samples result and zero and returns them as tagged responses over a second valid/ready handshake.
- Sits between an issuing agent (bench sequencer or multicycle control) and the ALU datapath.

Parameters:
DEPTH, 4, request FIFO entries (power of 2, >=2)
TAG_W, 4, width of the request sequence tag

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  FIFO can accept a request
req_op  input  3  ALU op code
req_first  input  32  first operand
req_second  input  32  second operand
alu_op  output  3  registered op to alu_32bit
alu_first  output  32  registered first operand to alu_32bit
alu_second  output  32  registered second operand to alu_32bit
alu_result  input  32  result from alu_32bit
alu_zero  input  1  zero flag from alu_32bit
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  32  captured result
rsp_zero  output  1  captured zero flag
rsp_tag  output  TAG_W  tag of the request that produced this response
rsp_illegal  output  1  op was not one of 000,001,010,110,111
busy  output  1  state != IDLE or FIFO non-empty

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous and active-low on reset_n; it is sampled only at the clk rising edge.
- Reset (reset_n=0 at a rising edge):
  - FIFO emptied; state goes to IDLE; tag counter set to 0.
  - alu_op, alu_first, alu_second, rsp_result, rsp_zero, rsp_tag, rsp_illegal and rsp_valid all 0.
  - req_ready=1 and busy=0 from the first cycle after reset.
  - Reset mid-operation discards all queued, executing and pending responses, with no partial output.
- Request acceptance:
  - A request is accepted at an edge where req_valid && req_ready.
  - The accepted entry {op, first, second, tag} is pushed, and the tag counter increments modulo 2^TAG_W, wrapping 15->0 at default.
- req_ready = FIFO not full, and is independent of req_valid. There is no bypass when full; a pop in the same cycle does not raise req_ready.
- FSM:
  - IDLE: if FIFO non-empty, pop the head into alu_op/alu_first/alu_second and a tag register, then go to EXEC. Otherwise stay.
  - EXEC (one cycle, lets the ALU settle):
    - Capture alu_result -> rsp_result and alu_zero -> rsp_zero.
    - Set rsp_tag and rsp_illegal.
    - Set rsp_valid=1 and go to RESP.
  - RESP: all rsp_* outputs are held stable while rsp_valid && !rsp_ready. On rsp_ready:
    - Clear rsp_valid.
    - If the FIFO is non-empty, pop the next entry and go to EXEC; otherwise go to IDLE.
- Latency and throughput:
  - Acceptance at edge N into an empty, idle block gives pop at N+1 and rsp_valid high after N+2.
  - Peak throughput is 1 response per 2 cycles.
- The alu_* outputs hold their last values after a pop and are not cleared in IDLE.
- Simultaneous push and pop in one cycle is allowed; occupancy is unchanged.
- Push into an empty FIFO is not visible to the FSM until the next edge.
- Capacity: DEPTH entries in the FIFO plus one in flight (EXEC/RESP). With rsp_ready=0, DEPTH+1 requests are accepted before req_ready falls.
- rsp_illegal is set for op in {011,100,101}. The result is still captured and returned; the block never drops a request.
- Ordering is strict FIFO: responses are returned in acceptance order with consecutive tags.

Test Plan:
1. Single request op=110, first=2, second=1, rsp_ready=1 -> 2 cycles after acceptance: rsp_valid=1, rsp_result=1, rsp_zero=0, rsp_tag=0, rsp_illegal=0.
2. Single request op=000, first=0xFFFFFFFF, second=0xFFFFFFFF, then op=110, first=5, second=5 -> first response result 0xFFFFFFFF, zero=0, tag 0; second response result 0, zero=1, tag 1.
3. Backpressure: rsp_ready=0, issue 6 back-to-back requests -> req_ready falls after the 5th acceptance. The first response is held stable with tag 0. Then raise rsp_ready=1 -> tags 0..5 are returned in order, 1 per 2 cycles.
4. Illegal op=011, first=7, second=3 -> response delivered with rsp_illegal=1, tag as expected, busy returns to 0 after the handshake.
5. Tag wrap: 17 sequential requests -> tags 0..15, then 0.
6. Reset mid-operation: 3 queued requests and rsp_valid=1, drive reset_n=0 for one edge -> next cycle rsp_valid=0, busy=0, req_ready=1, and the next request returns tag 0.
